life_engine: RTL and testbench
==============================

// Module: life_engine
// PURPOSE
//  Parametrised Game of Life generation engine for the VGA demoscene top level. It holds a
//  2^BIT_W x 2^BIT_H board and computes each new generation by scanning one cell per clk.
//  Rule is fixed B3/S23; edges are either dead or toroidal (wrap), selected at run time.
//  A registered display board gives the VGA renderer tear-free reads; host ports give run, step and load.
// PARAMETERS
//  BIT_W    3             log2 board width (W = 2**BIT_W)
//  BIT_H    3             log2 board height (H = 2**BIT_H); SIZE = W*H
//  GEN_DIV  8             accepted frame_ticks per generation while running (>=1)
//  SEED     glider@(1,0)  SIZE-bit reset pattern; bit index = y*W+x (8x8 default 'h70402)
// PORTS
//  clk         in   1          system clock (VGA pixel clock)
//  rst_n       in   1          reset, synchronous, active-low
//  frame_tick  in   1          1-cycle pulse per frame (vsync edge, made by top level)
//  run         in   1          1 = free-run at tick/GEN_DIV; 0 = paused
//  step        in   1          1-cycle pulse: one generation while paused
//  wrap        in   1          1 = toroidal edges; 0 = outside cells dead; sampled at start
//  load_en     in   1          write one cell of display board (honoured only in IDLE)
//  load_addr   in   BIT_W+BIT_H  cell index to write
//  load_val    in   1          value written
//  rd_x        in   BIT_W      renderer column
//  rd_y        in   BIT_H      renderer row
//  rd_alive    out  1          display board cell (rd_y*W+rd_x), combinational
//  busy        out  1          1 while COMPUTE/COMMIT in progress
//  gen_count   out  16         generations committed since reset, wraps at 65535->0
//  population  out  BIT_W+BIT_H+1  live cells in display board, updated at COMMIT
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): disp<=SEED, nxt<=0, state IDLE, busy 0, gen_count 0,
//    population = popcount(SEED) (constant fn), div_cnt 0, idx 0. Reset mid-COMPUTE aborts; no commit.
//  - States: IDLE -> COMPUTE -> COMMIT -> IDLE.
//  - IDLE: on frame_tick&run, div_cnt++; at div_cnt==GEN_DIV-1 clear it and start.
//    step&!run starts immediately. run=0 holds div_cnt. load_en writes disp[load_addr] and, on
//    the same cycle, takes priority over a start (start deferred, no event lost for step: ignored).
//  - Start: latch wrap into wrap_q, idx<=0, pop_acc<=0, busy<=1, state COMPUTE.
//  - COMPUTE: per clk, n = 8-neighbour count of disp at idx (4-bit); edge mode drops out-of-board
//    cells, wrap mode takes x,y modulo W,H (natural bit truncation). nxt[idx] <= (n==3)|(disp[idx]&n==2);
//    pop_acc += that value. idx==SIZE-1 -> COMMIT. Exactly SIZE cycles.
//  - COMMIT (1 clk): disp<=nxt, population<=pop_acc, gen_count++, busy<=0, IDLE.
//    Start-to-disp-update latency = SIZE+1 clks.
//  - frame_tick, step, load_en while busy are ignored (not queued). disp is stable during COMPUTE;
//    rd_alive never shows a partial generation.
//  - Empty board stays empty; gen_count still increments.
// STRUCTURE
//  - Shared package life_pkg: state encoding (IDLE/COMPUTE/COMMIT), rule constants BIRTH=3,
//    SURVIVE_LO=2, SURVIVE_HI=3, default SEED constant for 8x8.
//  - Sub-module life_neigh_count: combinational, params BIT_W/BIT_H, inputs board vector,
//    idx, wrap -> 4-bit count. Everything else in life_engine.
// TESTING
//  - Reset with default SEED -> rd_alive=1 at idx 1,10,16,17,18 only; population=5; gen_count=0; busy=0.
//  - Load blinker idx 26,27,28 (over empty board), step -> busy for 65 clks, then cells 19,27,35
//    live, population=3, gen_count=1; step again -> back to 26,27,28.
//  - Default glider, wrap=1, run=1, GEN_DIV=1, 32 ticks -> board equals SEED, population=5
//    after every generation, gen_count=32.
//  - Block at 0,1,8,9 with wrap=0 stays stable; same block with wrap=1 at 0,7,56,63 also stable;
//    with wrap=0 that corner set dies in one generation (population=0).
//  - frame_tick/step/load_en pulsed while busy=1 -> no extra generation, disp unchanged by load.
//  - rst_n=0 at COMPUTE cycle 20 -> next clk disp=SEED, busy=0, gen_count=0.

Source files
------------

// File: rtl/life_pkg.sv
// Shared constants for the Game of Life engine: FSM encoding, B3/S23 rule, default seed.
package life_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    localparam int BIRTH      = 3;
    localparam int SURVIVE_LO = 2;
    localparam int SURVIVE_HI = 3;

    // Glider with its top cell at (1,0) on an 8x8 board.
    localparam logic [63:0] SEED_8X8 = 64'h70402;

    function automatic logic cell_next(logic alive, logic [3:0] n);
        return (n == 4'(BIRTH)) ||
               (alive && (n >= 4'(SURVIVE_LO)) && (n <= 4'(SURVIVE_HI)));
    endfunction

endpackage

// File: rtl/life_neigh_count.sv
// Combinational 8-neighbour count of one cell, with dead or toroidal edges.
module life_neigh_count
    import life_pkg::*;
#(
    parameter int BIT_W = 3,
    parameter int BIT_H = 3
) (
    input  logic [2**(BIT_W+BIT_H)-1:0] board,
    input  logic [BIT_W+BIT_H-1:0]      idx,
    input  logic                        wrap,
    output logic [3:0]                  count
);

    logic [BIT_W-1:0] x;
    logic [BIT_H-1:0] y;
    logic [2:0][BIT_W-1:0] cx;
    logic [2:0][BIT_H-1:0] cy;
    logic [2:0] vx, vy;

    assign x = idx[BIT_W-1:0];
    assign y = idx[BIT_W+BIT_H-1:BIT_W];

    // Coordinates truncate naturally, which is exactly the torus; edge mode masks them off.
    assign cx = {x + 1'b1, x, x - 1'b1};
    assign cy = {y + 1'b1, y, y - 1'b1};
    assign vx = {wrap || (x != '1), 1'b1, wrap || (x != '0)};
    assign vy = {wrap || (y != '1), 1'b1, wrap || (y != '0)};

    always_comb begin
        count = '0;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(i == 1 && j == 1) && vx[i] && vy[j])
                    count = count + 4'(board[{cy[j], cx[i]}]);
            end
        end
    end

endmodule

// File: rtl/life_engine.sv
// Game of Life generation engine: scans one cell per clk into nxt, then commits to the display board.
module life_engine
    import life_pkg::*;
#(
    parameter int BIT_W   = 3,
    parameter int BIT_H   = 3,
    parameter int GEN_DIV = 8,
    parameter logic [2**(BIT_W+BIT_H)-1:0] SEED = SEED_8X8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_tick,
    input  logic                   run,
    input  logic                   step,
    input  logic                   wrap,
    input  logic                   load_en,
    input  logic [BIT_W+BIT_H-1:0] load_addr,
    input  logic                   load_val,
    input  logic [BIT_W-1:0]       rd_x,
    input  logic [BIT_H-1:0]       rd_y,
    output logic                   rd_alive,
    output logic                   busy,
    output logic [15:0]            gen_count,
    output logic [BIT_W+BIT_H:0]   population
);

    localparam int ADDR_W = BIT_W + BIT_H;
    localparam int SIZE   = 2**ADDR_W;
    localparam int POP_W  = ADDR_W + 1;
    localparam int DIV_W  = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;

    function automatic logic [POP_W-1:0] popcnt(logic [SIZE-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < SIZE; i++) c = c + POP_W'(v[i]);
        return c;
    endfunction

    localparam logic [POP_W-1:0] SEED_POP = popcnt(SEED);

    logic [1:0]        state;
    logic [SIZE-1:0]   disp, nxt;
    logic [ADDR_W-1:0] idx;
    logic [POP_W-1:0]  pop_acc;
    logic              wrap_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [3:0]        n_cnt;
    logic              cell_new, tick_last, go;

    life_neigh_count #(.BIT_W(BIT_W), .BIT_H(BIT_H)) u_neigh (
        .board (disp),
        .idx   (idx),
        .wrap  (wrap_q),
        .count (n_cnt)
    );

    assign cell_new  = cell_next(disp[idx], n_cnt);
    assign tick_last = (div_cnt == DIV_W'(GEN_DIV - 1));
    // A load in the same cycle swallows the start; the divider holds so the next tick retries.
    assign go        = !load_en && ((frame_tick && run && tick_last) || (step && !run));
    assign rd_alive  = disp[{rd_y, rd_x}];
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            disp       <= SEED;
            nxt        <= '0;
            idx        <= '0;
            pop_acc    <= '0;
            wrap_q     <= 1'b0;
            div_cnt    <= '0;
            gen_count  <= '0;
            population <= SEED_POP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_en)
                        disp[load_addr] <= load_val;
                    else if (frame_tick && run)
                        div_cnt <= tick_last ? '0 : div_cnt + 1'b1;
                    if (go) begin
                        wrap_q  <= wrap;
                        idx     <= '0;
                        pop_acc <= '0;
                        state   <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    nxt[idx] <= cell_new;
                    pop_acc  <= pop_acc + POP_W'(cell_new);
                    idx      <= idx + 1'b1;
                    if (idx == '1) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    disp       <= nxt;
                    population <= pop_acc;
                    gen_count  <= gen_count + 16'd1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Directed + random checks of life_engine against a 2-D array reference of the B3/S23 rule.
module tb_life_engine;

    logic       clk = 1'b0;
    logic       rst_n, frame_tick, run, step, wrap, load_en, load_val;
    logic [5:0] load_addr;
    logic [2:0] rd_x, rd_y;
    logic       rd_alive, busy;
    logic [15:0] gen_count;
    logic [6:0] population;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] SEED    = 64'h70402;
    localparam logic [63:0] BLINK_H = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    localparam logic [63:0] BLINK_V = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    localparam logic [63:0] BLOCK   = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);
    localparam logic [63:0] CORNERS = (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 56) | (64'd1 << 63);

    life_engine #(.BIT_W(3), .BIT_H(3), .GEN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
        .wrap(wrap), .load_en(load_en), .load_addr(load_addr), .load_val(load_val),
        .rd_x(rd_x), .rd_y(rd_y), .rd_alive(rd_alive), .busy(busy),
        .gen_count(gen_count), .population(population)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: count neighbours on a 2-D grid with plain coordinate arithmetic.
    function automatic logic [63:0] life_next(input logic [63:0] b, input bit wr);
        logic [63:0] r;
        r = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                int n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int xx = x + dx;
                        int yy = y + dy;
                        if (dx == 0 && dy == 0) continue;
                        if (wr) begin
                            xx = (xx + 8) % 8;
                            yy = (yy + 8) % 8;
                        end else if (xx < 0 || xx > 7 || yy < 0 || yy > 7) continue;
                        n += int'(b[yy * 8 + xx]);
                    end
                end
                r[y * 8 + x] = (n == 3) || (b[y * 8 + x] && n == 2);
            end
        end
        return r;
    endfunction

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic read_board(output logic [63:0] b);
        for (int a = 0; a < 64; a++) begin
            rd_x = 3'(a);
            rd_y = 3'(a >> 3);
            #1;
            b[a] = rd_alive;
        end
    endtask

    task automatic load_board(input logic [63:0] b);
        for (int a = 0; a < 64; a++) begin
            load_en = 1'b1;
            load_addr = 6'(a);
            load_val = b[a];
            clk1();
        end
        load_en = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            clk1();
        end
    endtask

    task automatic do_step(input bit wr, output int cyc);
        wrap = wr;
        step = 1'b1;
        clk1();
        step = 1'b0;
        wrap = !wr;
        wait_idle(cyc);
    endtask

    initial begin
        logic [63:0] cur, exp_b, got;
        int          cyc, exp_gen;
        bit          wr;
        rst_n = 1'b0; frame_tick = 0; run = 0; step = 0; wrap = 0;
        load_en = 0; load_addr = '0; load_val = 0; rd_x = '0; rd_y = '0;
        clk1(); clk1();
        rst_n = 1'b1;

        read_board(got);
        chk("reset_board", got, SEED);
        chk("reset_pop", 64'(population), 64'(5));
        chk("reset_gen", 64'(gen_count), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        exp_gen = 0;

        // Blinker oscillation
        load_board(BLINK_H);
        do_step(1'b0, cyc);
        exp_gen++;
        chk("blink_busy_cycles", 64'(cyc), 64'd65);
        read_board(got);
        chk("blink_vert", got, BLINK_V);
        chk("blink_pop", 64'(population), 64'd3);
        chk("blink_gen", 64'(gen_count), 64'(exp_gen));
        do_step(1'b0, cyc);
        exp_gen++;
        read_board(got);
        chk("blink_horiz", got, BLINK_H);

        // Still lifes and the edge-sensitive corner set
        load_board(BLOCK);
        do_step(1'b0, cyc);
        exp_gen++;
        read_board(got);
        chk("block_edge", got, BLOCK);
        load_board(CORNERS);
        do_step(1'b1, cyc);
        exp_gen++;
        read_board(got);
        chk("corner_wrap", got, CORNERS);
        chk("corner_wrap_pop", 64'(population), 64'd4);
        do_step(1'b0, cyc);
        exp_gen++;
        read_board(got);
        chk("corner_edge", got, 64'd0);
        chk("corner_edge_pop", 64'(population), 64'd0);
        do_step(1'b0, cyc);
        exp_gen++;
        chk("empty_gen", 64'(gen_count), 64'(exp_gen));
        read_board(got);
        chk("empty_board", got, 64'd0);

        // Random boards, random edge mode (wrap flips after start to prove it is latched)
        for (int k = 0; k < 6; k++) begin
            cur = {$urandom(), $urandom()};
            wr = 1'($urandom_range(0, 1));
            load_board(cur);
            exp_b = life_next(cur, wr);
            do_step(wr, cyc);
            exp_gen++;
            read_board(got);
            chk("rand_board", got, exp_b);
            chk("rand_pop", 64'(population), 64'($countones(exp_b)));
        end
        chk("rand_gen", 64'(gen_count), 64'(exp_gen));

        // Controls pulsed while busy must be ignored
        cur = got;
        exp_b = life_next(cur, 1'b0);
        wrap = 1'b0;
        step = 1'b1;
        clk1();
        step = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            step = (cyc == 5);
            load_en = (cyc == 10);
            load_addr = 6'd0;
            load_val = !cur[0];
            frame_tick = (cyc == 15);
            run = (cyc == 15);
            clk1();
        end
        step = 0; load_en = 0; frame_tick = 0; run = 0;
        exp_gen++;
        repeat (5) clk1();
        chk("busyign_cycles", 64'(cyc), 64'd65);
        chk("busyign_idle", 64'(busy), 64'd0);
        chk("busyign_gen", 64'(gen_count), 64'(exp_gen));
        read_board(got);
        chk("busyign_board", got, exp_b);

        // Reset in the middle of COMPUTE aborts the generation
        step = 1'b1;
        clk1();
        step = 1'b0;
        repeat (20) clk1();
        rst_n = 1'b0;
        clk1();
        rst_n = 1'b1;
        read_board(got);
        chk("midrst_board", got, SEED);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_gen", 64'(gen_count), 64'd0);
        chk("midrst_pop", 64'(population), 64'd5);

        // Free-running glider on a torus: every second tick starts a generation
        cur = SEED;
        run = 1'b1;
        wrap = 1'b1;
        for (int t = 1; t <= 64; t++) begin
            frame_tick = 1'b1;
            clk1();
            frame_tick = 1'b0;
            if (t % 2 == 0) begin
                chk("run_start", 64'(busy), 64'd1);
                wait_idle(cyc);
                cur = life_next(cur, 1'b1);
                chk("run_pop", 64'(population), 64'd5);
                read_board(got);
                chk("run_board", got, cur);
            end else begin
                chk("run_div_hold", 64'(busy), 64'd0);
                clk1();
            end
        end
        run = 1'b0;
        read_board(got);
        chk("glider_home", got, SEED);
        chk("glider_gen", 64'(gen_count), 64'd32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
